// File: rtl/i2c_host_ctrl.sv
// rtl/i2c_host_ctrl.sv - single-byte I2C register read/write host on open-drain SCL/SDA
// Optional clock stretching support is enabled with `define I2C_CLK_STRETCH_EN.
module i2c_host_ctrl #(
  parameter int         CLK_DIV  = 125,
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         CNT_W    = 8
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       SCL_host,
  output logic       SDA_host,
  input  logic       SCLi,
  input  logic       SDAi
);

  typedef enum logic [3:0] {
    IDLE, START, ADDRW, ACK, REG, WDATA, RSTART, ADDRR, RDATA, MNACK, STOP, BUF
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  state_t           state;
  state_t           ack_ret;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       quarter;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       rxreg;
  logic             ack_smp;
  logic             nack;
  logic             rw_q;
  logic [7:0]       reg_q;
  logic [7:0]       wdata_q;
  logic [1:0]       sda_sync;
  logic             sda_s;
  logic             scl_s;
  logic             stall;
  logic             q_end;
  logic             bit_end;
  logic             sample;

  assign busy  = ~cmd_ready;
  assign sda_s = sda_sync[1];

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) sda_sync <= 2'b11;
    else        sda_sync <= {sda_sync[0], SDAi};
  end

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] scl_sync;
  assign scl_s = scl_sync[1];
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) scl_sync <= 2'b11;
    else        scl_sync <= {scl_sync[0], SCLi};
  end
`else
  logic unused_scl;
  assign unused_scl = SCLi;
  assign scl_s      = 1'b1;
`endif

  function automatic logic scl_rel(input state_t s, input logic [1:0] q);
    case (s)
      IDLE, BUF:     scl_rel = 1'b1;
      START, RSTART: scl_rel = (q != 2'd3);
      default:       scl_rel = q[1];
    endcase
  endfunction

  function automatic logic sda_drv(input state_t s, input logic [1:0] q, input logic tx);
    case (s)
      START, RSTART:            sda_drv = ~q[1];
      STOP:                     sda_drv = (q == 2'd3);
      ADDRW, REG, WDATA, ADDRR: sda_drv = tx;
      default:                  sda_drv = 1'b1;
    endcase
  endfunction

  // A released-SCL quarter may not start counting until the wire is seen high.
  assign stall   = (state != IDLE) && scl_rel(state, quarter) && (cnt == '0) && !scl_s;
  assign q_end   = !stall && (cnt == CNT_MAX);
  assign bit_end = q_end && (quarter == 2'd3);
  assign sample  = q_end && (quarter == 2'd2);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ack_ret   <= IDLE;
      cnt       <= '0;
      quarter   <= 2'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      rxreg     <= 8'h00;
      ack_smp   <= 1'b0;
      nack      <= 1'b0;
      rw_q      <= 1'b0;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
      SCL_host  <= 1'b1;
      SDA_host  <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      SCL_host  <= scl_rel(state, quarter);
      SDA_host  <= sda_drv(state, quarter, shreg[7]);

      if (state != IDLE && !stall) begin
        if (q_end) begin
          cnt     <= '0;
          quarter <= quarter + 2'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          cnt     <= '0;
          quarter <= 2'd0;
          if (cmd_ready) begin
            if (cmd_valid) begin
              rw_q      <= cmd_rw;
              reg_q     <= cmd_reg;
              wdata_q   <= cmd_wdata;
              cmd_ready <= 1'b0;
            end
          end else begin
            state   <= START;
            nack    <= 1'b0;
            bit_idx <= 3'd0;
            rxreg   <= 8'h00;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= ADDRW;
            shreg   <= {DEV_ADDR, 1'b0};
            bit_idx <= 3'd0;
          end
        end
        RSTART: begin
          if (bit_end) begin
            state   <= ADDRR;
            shreg   <= {DEV_ADDR, 1'b1};
            bit_idx <= 3'd0;
          end
        end
        ADDRW, REG, WDATA, ADDRR: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= ACK;
              case (state)
                ADDRW:   ack_ret <= REG;
                REG:     ack_ret <= rw_q ? RSTART : WDATA;
                ADDRR:   ack_ret <= RDATA;
                default: ack_ret <= STOP;
              endcase
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {shreg[6:0], 1'b0};
            end
          end
        end
        ACK: begin
          if (sample) ack_smp <= sda_s;
          if (bit_end) begin
            bit_idx <= 3'd0;
            if (ack_smp) begin
              nack  <= 1'b1;
              state <= STOP;
            end else begin
              state <= ack_ret;
              if (ack_ret == REG)   shreg <= reg_q;
              if (ack_ret == WDATA) shreg <= wdata_q;
            end
          end
        end
        RDATA: begin
          if (sample) rxreg <= {rxreg[6:0], sda_s};
          if (bit_end) begin
            if (bit_idx == 3'd7) state <= MNACK;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        MNACK: begin
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (bit_end) begin
            state     <= BUF;
            rsp_valid <= 1'b1;
            rsp_nack  <= nack;
            rsp_rdata <= (rw_q && !nack) ? rxreg : 8'h00;
          end
        end
        BUF: begin
          if (bit_end) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_host_ctrl.sv
// tb/tb_i2c_host_ctrl.sv - directed bench for i2c_host_ctrl with a behavioural I2C target
// Also exercises clock stretching when built with `define I2C_CLK_STRETCH_EN.
module tb_i2c_host_ctrl;

  localparam int DIV     = 50;
  localparam int WR_LAT  = 116 * DIV + 1;
  localparam int RD_LAT  = 156 * DIV + 1;
  localparam int NK_LAT  = 44 * DIV + 1;
  localparam int BUF_LEN = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_reg = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       SCL_host;
  logic       SDA_host;
  logic       SCLi;
  logic       SDAi;

  logic       tgt_sda = 1'b1;
  logic       tgt_scl = 1'b1;
  logic [6:0] tgt_addr = 7'h3C;

  assign SDAi = SDA_host & tgt_sda;
  assign SCLi = SCL_host & tgt_scl;

  i2c_host_ctrl #(.CLK_DIV(DIV), .DEV_ADDR(7'h3C), .CNT_W(8)) dut (
    .clk_50M(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
    .SCL_host(SCL_host), .SDA_host(SDA_host), .SCLi(SCLi), .SDAi(SDAi)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural target: decodes the host drive, answers on the resolved wire.
  logic [7:0] mem [256];
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         bitn = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  logic [7:0] t_sh = 8'h00;
  logic [7:0] t_addr = 8'h00;
  logic [7:0] t_reg = 8'h00;
  logic [7:0] blog [$];
  logic       alog [$];
  logic       stretch_arm = 1'b0;
  int         hold = 0;

  always @(negedge clk) begin
    int pos, k;
    logic b, addressed;
    logic [7:0] d;
    if (hold > 0) begin
      hold--;
      if (hold == 0) tgt_scl = 1'b1;
    end
    pos = bitn % 9;
    k   = bitn / 9;
    addressed = (t_addr[7:1] == tgt_addr);
    if (SCL_host && prev_scl && prev_sda && !SDA_host) begin
      start_cnt++;
      bitn = 0;
    end else if (SCL_host && prev_scl && !prev_sda && SDA_host) begin
      stop_cnt++;
    end else if (SCL_host && !prev_scl) begin
      b = SDAi;
      if (stretch_arm && bitn == 12) begin
        tgt_scl = 1'b0;
        hold = 500;
        stretch_arm = 1'b0;
      end
      if (pos == 8) begin
        alog.push_back(b);
      end else begin
        t_sh = {t_sh[6:0], b};
        if (pos == 7) begin
          blog.push_back(t_sh);
          if (k == 0) t_addr = t_sh;
          else if (t_addr == {tgt_addr, 1'b0}) begin
            if (k == 1) t_reg = t_sh;
            if (k == 2) mem[t_reg] = t_sh;
          end
        end
      end
      bitn++;
    end else if (!SCL_host && prev_scl) begin
      d = mem[t_reg];
      if (pos == 8 && k == 0)                           tgt_sda = !addressed;
      else if (pos == 8 && addressed && !t_addr[0])     tgt_sda = 1'b0;
      else if (k == 1 && pos < 8 && addressed && t_addr[0]) tgt_sda = d[7-pos];
      else                                              tgt_sda = 1'b1;
    end
    prev_scl = SCL_host;
    prev_sda = SDA_host;
  end

  task automatic clear_log();
    blog.delete();
    alog.delete();
    start_cnt = 0;
    stop_cnt  = 0;
  endtask

  task automatic issue(input logic rw, input logic [7:0] r, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_reg   = r;
    cmd_wdata = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic rw, input logic [7:0] r, input logic [7:0] d,
                        output int lat, output int rdy);
    clear_log();
    issue(rw, r, d);
    lat = 0;
    while (lat < 40000) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid) break;
    end
    rdy = 0;
    while (rdy < 2000) begin
      @(posedge clk);
      rdy++;
      #1;
      if (cmd_ready) break;
    end
  endtask

  initial begin
    int lat, rdy, base;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", SCL_host, 1);
    check("rst_sda", SDA_host, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 8'h00);
    check("rst_nack", rsp_nack, 0);

    // write reg 03 = A5
    do_cmd(1'b0, 8'h03, 8'hA5, lat, rdy);
`ifndef I2C_CLK_STRETCH_EN
    check("wr_latency", lat, WR_LAT);
`endif
    check("wr_buf_len", rdy, BUF_LEN);
    check("wr_nack", rsp_nack, 0);
    check("wr_rdata", rsp_rdata, 8'h00);
    check("wr_nbytes", blog.size(), 3);
    check("wr_b0", blog[0], 8'h78);
    check("wr_b1", blog[1], 8'h03);
    check("wr_b2", blog[2], 8'hA5);
    check("wr_acks", {alog.size(), 1'b0, alog[0], alog[1], alog[2]}, {32'd3, 4'b0000} >> 0);
    check("wr_start_stop", {start_cnt[7:0], stop_cnt[7:0]}, 16'h0101);
    check("wr_mem", mem[3], 8'hA5);

    // read reg 03
    do_cmd(1'b1, 8'h03, 8'h00, lat, rdy);
`ifndef I2C_CLK_STRETCH_EN
    check("rd_latency", lat, RD_LAT);
`endif
    check("rd_rdata", rsp_rdata, 8'hA5);
    check("rd_nack", rsp_nack, 0);
    check("rd_nbytes", blog.size(), 4);
    check("rd_b0", blog[0], 8'h78);
    check("rd_b1", blog[1], 8'h03);
    check("rd_b2", blog[2], 8'h79);
    check("rd_b3", blog[3], 8'hA5);
    check("rd_acks", {alog[0], alog[1], alog[2], alog[3]}, 4'b0001);
    check("rd_start_stop", {start_cnt[7:0], stop_cnt[7:0]}, 16'h0201);
    check("rd_valid_pulse", rsp_valid, 0);

    // target at another address never acknowledges
    tgt_addr = 7'h2A;
    do_cmd(1'b0, 8'h05, 8'h11, lat, rdy);
`ifndef I2C_CLK_STRETCH_EN
    check("nk_latency", lat, NK_LAT);
`endif
    check("nk_nack", rsp_nack, 1);
    check("nk_rdata", rsp_rdata, 8'h00);
    check("nk_nbytes", blog.size(), 1);
    check("nk_b0", blog[0], 8'h78);
    check("nk_ackbit", alog[0], 1);
    check("nk_stop", stop_cnt, 1);
    check("nk_ready", cmd_ready, 1);
    tgt_addr = 7'h3C;

    // second command pulsed while busy is dropped
    fork
      do_cmd(1'b0, 8'h10, 8'h5A, lat, rdy);
      begin
        repeat (300) @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_reg   = 8'h07;
        cmd_wdata = 8'h33;
        @(negedge clk);
        cmd_valid = 1'b0;
      end
    join
    repeat (400) @(posedge clk);
    #1;
    check("bz_nbytes", blog.size(), 3);
    check("bz_b1", blog[1], 8'h10);
    check("bz_b2", blog[2], 8'h5A);
    check("bz_starts", start_cnt, 1);
    check("bz_mem07", mem[7], 8'h00);
    check("bz_ready", cmd_ready, 1);

    // reset while the REG byte is on the bus
    clear_log();
    issue(1'b0, 8'h20, 8'hC3);
    repeat (2600) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mr_scl", SCL_host, 1);
    check("mr_sda", SDA_host, 1);
    check("mr_ready", cmd_ready, 1);
    tgt_sda = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    do_cmd(1'b0, 8'h21, 8'h3C, lat, rdy);
    base = lat;
`ifndef I2C_CLK_STRETCH_EN
    check("mr_wr_latency", lat, WR_LAT);
`endif
    check("mr_wr_nack", rsp_nack, 0);
    check("mr_wr_mem", mem[8'h21], 8'h3C);
    check("mr_lost_mem", mem[8'h20], 8'h00);

`ifdef I2C_CLK_STRETCH_EN
    stretch_arm = 1'b1;
    do_cmd(1'b0, 8'h21, 8'h96, lat, rdy);
    check("st_delay", lat - base, 500);
    check("st_mem", mem[8'h21], 8'h96);
    check("st_nack", rsp_nack, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
